fifo_rd_unpacker: RTL and testbench
===================================

# fifo_rd_unpacker

Downstream drain stage for the 128-bit FIFO. Issues read strobes into the FIFO, absorbs its one-cycle read latency in a 2-entry word buffer, and unpacks each 128-bit word into OUT_W-bit beats on a valid/ready stream. Never reads an empty FIFO, never drops a word, and sustains one FIFO read per RATIO output cycles with no bubbles.

## Interface
- IN_W, 128, FIFO word width; must equal the FIFO data width.
- OUT_W, 32, output beat width; IN_W % OUT_W == 0.
- RATIO, IN_W/OUT_W (derived localparam), beats per word; 1 = pass-through.
- clk  input  1  single clock; all logic on posedge.
- reset  input  1  synchronous, active-high; same reset as the FIFO.
- o_rden  output  1  read strobe into FIFO i_rden.
- i_empty  input  1  FIFO o_empty.
- i_alm_empty  input  1  FIFO o_alm_empty; status only, not used for flow control.
- i_rddata  input  IN_W  FIFO o_rddata; valid exactly 1 cycle after o_rden.
- o_valid  output  1  output beat valid.
- i_ready  input  1  sink ready.
- o_data  output  OUT_W  current beat.
- o_last  output  1  last beat of the current word.
- o_busy  output  1  buffer non-empty or read in flight.

## Operation
- State: buffer count cnt (0..2), in-flight flag infl (1 = read issued last cycle), beat counter beat (0..RATIO-1).
- pop = o_valid && i_ready && o_last.
- o_rden = !i_empty && (cnt + infl - pop) < 2. Combinational; i_ready-to-o_rden path is permitted.
- infl <= o_rden each cycle. When infl is set, i_rddata is written into the buffer tail.
- o_valid = (cnt != 0). o_data = head word bits [beat*OUT_W +: OUT_W], with beat 0 the least-significant slice. o_last = (beat == RATIO-1).
- Handshake (o_valid && i_ready): beat increments; on the last beat, beat returns to 0 and the head word pops.
- Simultaneous push and pop: cnt unchanged, order preserved.
- AXI-style stability: once o_valid rises, o_data and o_last hold until the handshake completes.
- o_busy = (cnt != 0) || infl.
- Overflow cannot occur by construction. A push with cnt == 2 and no pop is an assertion failure.

## Timing
- Reset values: o_rden 0, o_valid 0, o_data 0, o_last 0, o_busy 0, cnt 0, infl 0, beat 0.
- First-word latency: with i_empty low in cycle T, o_rden is high in T, data is captured at the end of T+1, and o_valid is high in T+2.
- Steady state with i_ready held at 1:
  - RATIO = 1: one word per cycle, no bubbles.
  - RATIO = 4: one o_rden every 4 cycles and continuous o_valid.
- Backpressure (i_ready low): reads continue until cnt + infl == 2, then o_rden holds low.
- Reset mid-operation: all state clears on the reset edge. A read in flight at reset is discarded, and the FIFO resets together with this block. The first o_rden can occur in the cycle after reset deasserts.
- i_empty rising while a read is in flight: the in-flight word is still captured, and no further reads are issued.

## Structure
- Shared package fifo_pkg holds: FIFO_DATA_W = 128, the default OUT_W, and typedef fifo_word_t (logic [FIFO_DATA_W-1:0]).
- One sub-module, fifo_rd_wordbuf: a 2-entry register FIFO with push/pop/cnt and head output, parameterised by width.
- The top level holds the o_rden credit logic, the infl register, and the beat counter/slice mux.

## Test plan
- Single word 128'h00000004_00000003_00000002_00000001, RATIO=4, i_ready=1:
  - exactly one o_rden is issued.
  - beats 1, 2, 3, 4 appear in cycles T+2..T+5.
  - o_last is high only on beat 4.
  - o_busy is low afterwards.
- 16 words back-to-back, RATIO=1, i_ready=1: after the first word, o_valid stays high for 16 consecutive cycles; data is in order with no gaps.
- Hold i_ready=0 with 10 words in the FIFO:
  - exactly 2 o_rden pulses, then none.
  - cnt = 2 and o_data is stable.
  - releasing i_ready drains all 10 words in order.
- Random i_ready (50%) with 64 random words, RATIO=4: the scoreboard matches 256 beats, o_rden is never high while i_empty is high, and the overflow assertion never fires.
- Assert reset in the cycle after o_rden:
  - all outputs are 0 in the next cycle.
  - the in-flight word is not emitted.
  - after refilling with 128'hA5, the first beat is 32'hA5.
- FIFO holds 1 word and i_empty rises in the cycle after the read: exactly 1 word is emitted, and no second o_rden is issued.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO datapath constants and word type for the 128-bit FIFO and its drain stage.
package fifo_pkg;
    localparam int unsigned FIFO_DATA_W = 128;
    localparam int unsigned FIFO_OUT_W  = 32;

    typedef logic [FIFO_DATA_W-1:0] fifo_word_t;
endpackage

// File: rtl/fifo_rd_unpacker_if.sv
// FIFO read port plus valid/ready beat stream seen by the drain stage.
interface fifo_rd_unpacker_if #(
    parameter int unsigned IN_W  = fifo_pkg::FIFO_DATA_W,
    parameter int unsigned OUT_W = fifo_pkg::FIFO_OUT_W
);
    logic             o_rden;
    logic             i_empty;
    logic             i_alm_empty;
    logic [IN_W-1:0]  i_rddata;
    logic             o_valid;
    logic             i_ready;
    logic [OUT_W-1:0] o_data;
    logic             o_last;
    logic             o_busy;

    modport master (
        output o_rden,
        input  i_empty,
        input  i_alm_empty,
        input  i_rddata,
        output o_valid,
        input  i_ready,
        output o_data,
        output o_last,
        output o_busy
    );

    modport slave (
        input  o_rden,
        output i_empty,
        output i_alm_empty,
        output i_rddata,
        input  o_valid,
        output i_ready,
        input  o_data,
        input  o_last,
        input  o_busy
    );
endinterface

// File: rtl/fifo_rd_wordbuf.sv
// Two-entry register FIFO that soaks up the FIFO's one-cycle read latency.
module fifo_rd_wordbuf #(
    parameter int unsigned W = 128
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] head,
    output logic [1:0]   cnt
);
    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         rd_ptr_q, rd_ptr_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic [1:0]   cnt_q, cnt_d;

    always_comb begin
        mem_d[0] = mem_q[0];
        mem_d[1] = mem_q[1];
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign head = mem_q[rd_ptr_q];
    assign cnt  = cnt_q;

    // Credit logic upstream guarantees these never trigger.
    a_no_overflow:  assert property (@(posedge clk) disable iff (reset) !(push && !pop && cnt_q == 2'd2));
    a_no_underflow: assert property (@(posedge clk) disable iff (reset) !(pop && cnt_q == 2'd0));
endmodule

// File: rtl/fifo_rd_unpacker.sv
// FIFO drain stage: credit-based read strobes, 2-entry landing buffer, word-to-beat unpacking.
module fifo_rd_unpacker
    import fifo_pkg::*;
#(
    parameter int unsigned IN_W  = FIFO_DATA_W,
    parameter int unsigned OUT_W = FIFO_OUT_W
) (
    input logic                clk,
    input logic                reset,
    fifo_rd_unpacker_if.master bus
);
    localparam int unsigned RATIO  = IN_W / OUT_W;
    localparam int unsigned BEAT_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    logic              infl_q, infl_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [1:0]        cnt;
    logic [IN_W-1:0]   head;
    logic [OUT_W-1:0]  data_c;
    logic              valid_c;
    logic              last_c;
    logic              hs_c;
    logic              pop_c;
    logic              rden_c;
    logic [2:0]        credit_c;
    logic              alm_empty_unused;

    assign alm_empty_unused = bus.i_alm_empty;

    // Slots committed after this edge: buffered words plus the one in flight, less the one leaving.
    always_comb begin
        valid_c  = (cnt != 2'd0);
        last_c   = (beat_q == BEAT_W'(RATIO - 1));
        hs_c     = valid_c && bus.i_ready;
        pop_c    = hs_c && last_c;
        credit_c = {1'b0, cnt} + {2'b00, infl_q} - {2'b00, pop_c};
        rden_c   = !bus.i_empty && (credit_c < 3'd2);
        infl_d   = rden_c;
        beat_d   = beat_q;
        if (hs_c) begin
            beat_d = last_c ? '0 : beat_q + BEAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            infl_q <= 1'b0;
            beat_q <= '0;
        end else begin
            infl_q <= infl_d;
            beat_q <= beat_d;
        end
    end

    fifo_rd_wordbuf #(
        .W(IN_W)
    ) u_buf (
        .clk  (clk),
        .reset(reset),
        .push (infl_q),
        .pop  (pop_c),
        .wdata(bus.i_rddata),
        .head (head),
        .cnt  (cnt)
    );

    // Beat 0 is the least-significant slice of the head word.
    if (RATIO == 1) begin : g_pass
        assign data_c = head;
    end else begin : g_mux
        logic [OUT_W-1:0] beats [RATIO];
        for (genvar g = 0; g < RATIO; g++) begin : g_beat
            assign beats[g] = head[g*OUT_W +: OUT_W];
        end
        assign data_c = beats[beat_q];
    end

    assign bus.o_rden  = rden_c;
    assign bus.o_valid = valid_c;
    assign bus.o_data  = data_c;
    assign bus.o_last  = valid_c && last_c;
    assign bus.o_busy  = valid_c || infl_q;
endmodule

// File: tb/tb_fifo_rd_unpacker.sv
// Bench for fifo_rd_unpacker: RATIO=4 and RATIO=1 instances, each fed by a queue-based FIFO model.
module tb_fifo_rd_unpacker;
    import fifo_pkg::*;

    typedef struct {
        logic        ready;
        logic        rden;
        logic        valid;
        logic [31:0] data;
        logic        last;
        logic        busy;
    } vec_t;

    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fifo_rd_unpacker_if #(.IN_W(FIFO_DATA_W), .OUT_W(32))          bus4 ();
    fifo_rd_unpacker_if #(.IN_W(FIFO_DATA_W), .OUT_W(FIFO_DATA_W)) bus1 ();

    fifo_rd_unpacker #(.IN_W(FIFO_DATA_W), .OUT_W(32)) u_dut4 (
        .clk  (clk),
        .reset(reset),
        .bus  (bus4)
    );

    fifo_rd_unpacker #(.IN_W(FIFO_DATA_W), .OUT_W(FIFO_DATA_W)) u_dut1 (
        .clk  (clk),
        .reset(reset),
        .bus  (bus1)
    );

    int checks   = 0;
    int failures = 0;
    int rd_cnt4  = 0;
    int rd_cnt1  = 0;
    int hs_cnt4  = 0;
    int hs_cnt1  = 0;

    fifo_word_t  q4[$], pend4[$], q1[$], pend1[$];
    logic [31:0] exp4_data[$];
    logic        exp4_last[$];
    fifo_word_t  exp1[$];

    logic        stall4;
    logic [31:0] hold_data4;
    logic        hold_last4;

    task automatic chk_b(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic chk_w(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic fifo_word_t rand_word();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Reference: a word becomes four 32-bit beats, LSB slice first, last flag on the fourth.
    task automatic push4(input fifo_word_t w);
        pend4.push_back(w);
        for (int b = 0; b < 4; b++) begin
            exp4_data.push_back(32'(w >> (32 * b)));
            exp4_last.push_back(b == 3);
        end
    endtask

    task automatic push1(input fifo_word_t w);
        pend1.push_back(w);
        exp1.push_back(w);
    endtask

    // FIFO models: one-cycle read latency, empty flag registered on the clock edge.
    always @(posedge clk) begin
        if (reset) begin
            q4.delete();
            pend4.delete();
            bus4.i_empty     <= 1'b1;
            bus4.i_alm_empty <= 1'b1;
            bus4.i_rddata    <= '0;
        end else begin
            if (bus4.o_rden) begin
                rd_cnt4++;
                if (q4.size() != 0) bus4.i_rddata <= q4.pop_front();
            end
            while (pend4.size() != 0) q4.push_back(pend4.pop_front());
            bus4.i_empty     <= (q4.size() == 0);
            bus4.i_alm_empty <= (q4.size() <= 1);
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            q1.delete();
            pend1.delete();
            bus1.i_empty     <= 1'b1;
            bus1.i_alm_empty <= 1'b1;
            bus1.i_rddata    <= '0;
        end else begin
            if (bus1.o_rden) begin
                rd_cnt1++;
                if (q1.size() != 0) bus1.i_rddata <= q1.pop_front();
            end
            while (pend1.size() != 0) q1.push_back(pend1.pop_front());
            bus1.i_empty     <= (q1.size() == 0);
            bus1.i_alm_empty <= (q1.size() <= 1);
        end
    end

    // Scoreboard and protocol monitor for the RATIO=4 stream.
    always @(negedge clk) begin
        #2;
        if (reset) begin
            exp4_data.delete();
            exp4_last.delete();
            stall4 = 1'b0;
        end else begin
            if (bus4.i_empty) chk_b("rden_while_empty4", bus4.o_rden, 1'b0);
            if (stall4) begin
                chk_b("hold_valid4", bus4.o_valid, 1'b1);
                chk_w("hold_data4", 128'(bus4.o_data), 128'(hold_data4));
                chk_b("hold_last4", bus4.o_last, hold_last4);
            end
            if (bus4.o_valid && bus4.i_ready) begin
                hs_cnt4++;
                chk_b("beat_expected4", exp4_data.size() != 0, 1'b1);
                if (exp4_data.size() != 0) begin
                    chk_w("beat_data4", 128'(bus4.o_data), 128'(exp4_data.pop_front()));
                    chk_b("beat_last4", bus4.o_last, exp4_last.pop_front());
                end
            end
            stall4     = bus4.o_valid && !bus4.i_ready;
            hold_data4 = bus4.o_data;
            hold_last4 = bus4.o_last;
        end
    end

    always @(negedge clk) begin
        #2;
        if (reset) begin
            exp1.delete();
        end else begin
            if (bus1.i_empty) chk_b("rden_while_empty1", bus1.o_rden, 1'b0);
            if (bus1.o_valid && bus1.i_ready) begin
                hs_cnt1++;
                chk_b("beat_expected1", exp1.size() != 0, 1'b1);
                if (exp1.size() != 0) begin
                    chk_w("beat_data1", bus1.o_data, exp1.pop_front());
                    chk_b("beat_last1", bus1.o_last, 1'b1);
                end
            end
        end
    end

    initial begin
        vec_t tbl [8];
        int   rd0, hs0, n, pushed, cyc, run;

        // Single word, RATIO=4: read in T, beats in T+2..T+5, idle from T+6.
        tbl[0] = '{1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 32'd1, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 32'd2, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 32'd3, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 32'd4, 1'b1, 1'b1};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0};

        reset        = 1'b1;
        bus4.i_ready = 1'b0;
        bus1.i_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_b("rst_rden", bus4.o_rden, 1'b0);
        chk_b("rst_valid", bus4.o_valid, 1'b0);
        chk_w("rst_data", 128'(bus4.o_data), 128'd0);
        chk_b("rst_last", bus4.o_last, 1'b0);
        chk_b("rst_busy", bus4.o_busy, 1'b0);
        chk_b("rst_last1", bus1.o_last, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        @(negedge clk);
        rd0 = rd_cnt4;
        hs0 = hs_cnt4;
        push4(128'h00000004_00000003_00000002_00000001);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus4.i_ready = tbl[i].ready;
            #1;
            chk_b($sformatf("tbl%0d_rden", i), bus4.o_rden, tbl[i].rden);
            chk_b($sformatf("tbl%0d_valid", i), bus4.o_valid, tbl[i].valid);
            chk_b($sformatf("tbl%0d_last", i), bus4.o_last, tbl[i].last);
            chk_b($sformatf("tbl%0d_busy", i), bus4.o_busy, tbl[i].busy);
            if (tbl[i].valid) chk_w($sformatf("tbl%0d_data", i), 128'(bus4.o_data), 128'(tbl[i].data));
        end
        chk_i("single_rden_count", rd_cnt4 - rd0, 1);
        chk_i("single_beats", hs_cnt4 - hs0, 4);

        // One word in the FIFO, empty rises the cycle after the read.
        @(negedge clk);
        rd0 = rd_cnt4;
        hs0 = hs_cnt4;
        push4(rand_word());
        repeat (10) @(negedge clk);
        #1;
        chk_i("one_word_rden", rd_cnt4 - rd0, 1);
        chk_i("one_word_beats", hs_cnt4 - hs0, 4);
        chk_b("one_word_busy", bus4.o_busy, 1'b0);

        // Backpressure with 10 words queued.
        @(negedge clk);
        bus4.i_ready = 1'b0;
        rd0 = rd_cnt4;
        hs0 = hs_cnt4;
        for (int i = 0; i < 10; i++) push4(rand_word());
        repeat (12) @(negedge clk);
        #1;
        chk_i("bp_rden_count", rd_cnt4 - rd0, 2);
        chk_b("bp_rden_low", bus4.o_rden, 1'b0);
        chk_i("bp_buf_cnt", int'(u_dut4.u_buf.cnt_q), 2);
        chk_b("bp_valid", bus4.o_valid, 1'b1);
        chk_w("bp_head", 128'(bus4.o_data), 128'(exp4_data[0]));
        chk_i("bp_no_beats", hs_cnt4 - hs0, 0);
        @(negedge clk);
        bus4.i_ready = 1'b1;
        n = 0;
        while ((exp4_data.size() != 0 || bus4.o_busy) && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk_i("bp_drain_left", exp4_data.size(), 0);
        chk_i("bp_beats", hs_cnt4 - hs0, 40);

        // Random sink readiness and random arrival of 64 words.
        hs0    = hs_cnt4;
        pushed = 0;
        cyc    = 0;
        while ((hs_cnt4 - hs0) < 256 && cyc < 4000) begin
            @(negedge clk);
            bus4.i_ready = 1'($urandom_range(0, 1));
            if (pushed < 64 && $urandom_range(0, 3) != 0) begin
                push4(rand_word());
                pushed++;
            end
            cyc++;
        end
        bus4.i_ready = 1'b1;
        chk_i("rand_beats", hs_cnt4 - hs0, 256);
        chk_i("rand_left", exp4_data.size(), 0);

        // Reset lands while a read is in flight.
        repeat (4) @(negedge clk);
        push4(rand_word());
        @(negedge clk);
        #1;
        chk_b("rst_fl_rden", bus4.o_rden, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_b("rst_fl_rden_out", bus4.o_rden, 1'b0);
        chk_b("rst_fl_valid", bus4.o_valid, 1'b0);
        chk_w("rst_fl_data", 128'(bus4.o_data), 128'd0);
        chk_b("rst_fl_last", bus4.o_last, 1'b0);
        chk_b("rst_fl_busy", bus4.o_busy, 1'b0);
        hs0 = hs_cnt4;
        repeat (6) @(negedge clk);
        chk_i("rst_fl_no_beat", hs_cnt4 - hs0, 0);
        @(negedge clk);
        push4(128'hA5);
        n = 0;
        while (!bus4.o_valid && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk_b("refill_valid", bus4.o_valid, 1'b1);
        chk_w("refill_beat0", 128'(bus4.o_data), 128'h0000_00A5);
        repeat (8) @(negedge clk);
        chk_i("refill_left", exp4_data.size(), 0);

        // RATIO=1: 16 words back-to-back with no bubbles.
        @(negedge clk);
        bus1.i_ready = 1'b1;
        rd0 = rd_cnt1;
        for (int i = 0; i < 16; i++) push1(rand_word());
        n = 0;
        while (!bus1.o_valid && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk_b("r1_valid_start", bus1.o_valid, 1'b1);
        run = 0;
        while (bus1.o_valid && run < 20) begin
            run++;
            @(negedge clk);
            #1;
        end
        chk_i("r1_run", run, 16);
        chk_i("r1_left", exp1.size(), 0);
        chk_i("r1_reads", rd_cnt1 - rd0, 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
